// File: rtl/rename_rat.sv
// 4-wide register-rename map stage: speculative RAT lookup/update with intra-group bypass,
// architectural RAT at retire, flush restore. Optional stall counter: RENAME_PERF_CNT_EN.
module rename_rat #(
  parameter int AR_W = 5,
  parameter int PR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_stage4,
  input  logic              stage4_pause,
  input  logic [3:0]        in_valid,
  input  logic [4*AR_W-1:0] src1_AR,
  input  logic [4*AR_W-1:0] src2_AR,
  input  logic [4*AR_W-1:0] dst_AR,
  input  logic [3:0]        dst_wen,
  input  logic [4*PR_W-1:0] free_PR,
  input  logic [5:0]        freelist_room,
  output logic [2:0]        PR_num_need,
  output logic              rename_stall,
  output logic [3:0]        out_valid,
  output logic [4*PR_W-1:0] src1_PR,
  output logic [4*PR_W-1:0] src2_PR,
  output logic [4*PR_W-1:0] dst_PR,
  output logic [4*PR_W-1:0] old_PR,
  input  logic [3:0]        retire_valid,
  input  logic [4*AR_W-1:0] retire_AR,
  input  logic [4*PR_W-1:0] retire_PR
`ifdef RENAME_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);
  localparam int NAR = 1 << AR_W;

  logic [PR_W-1:0] srat_reg [NAR];
  logic [PR_W-1:0] arat_reg [NAR];
  logic [PR_W-1:0] arat_next [NAR];

  logic [AR_W-1:0] s1_ar [4];
  logic [AR_W-1:0] s2_ar [4];
  logic [AR_W-1:0] d_ar  [4];
  logic [AR_W-1:0] r_ar  [4];
  logic [PR_W-1:0] f_pr  [4];
  logic [PR_W-1:0] r_pr  [4];
  logic [3:0]      rn;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_unpack
      assign s1_ar[gi] = src1_AR[gi*AR_W +: AR_W];
      assign s2_ar[gi] = src2_AR[gi*AR_W +: AR_W];
      assign d_ar[gi]  = dst_AR[gi*AR_W +: AR_W];
      assign r_ar[gi]  = retire_AR[gi*AR_W +: AR_W];
      assign f_pr[gi]  = free_PR[gi*PR_W +: PR_W];
      assign r_pr[gi]  = retire_PR[gi*PR_W +: PR_W];
      assign rn[gi]    = in_valid[gi] & dst_wen[gi] & (d_ar[gi] != '0);
    end
  endgenerate

  // Free PRs are handed out densely in slot order to renaming slots only.
  logic [PR_W-1:0] alloc_pr [4];
  logic [2:0]      need_raw;
  always_comb begin
    need_raw = 3'd0;
    for (int k = 0; k < 4; k++) begin
      alloc_pr[k] = '0;
      if (rn[k]) begin
        alloc_pr[k] = f_pr[need_raw[1:0]];
        need_raw    = need_raw + 3'd1;
      end
    end
  end

  logic fire;
  assign rename_stall = ({3'b000, need_raw} > freelist_room);
  assign fire         = ~rename_stall & ~stage4_pause & ~flush_stage4;
  assign PR_num_need  = fire ? need_raw : 3'd0;

  // Later older slots override earlier ones, so the youngest older writer wins.
  logic [PR_W-1:0] l1 [4];
  logic [PR_W-1:0] l2 [4];
  logic [PR_W-1:0] lo [4];
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      l1[k] = srat_reg[s1_ar[k]];
      l2[k] = srat_reg[s2_ar[k]];
      lo[k] = srat_reg[d_ar[k]];
      for (int m = 0; m < k; m++) begin
        if (rn[m] && d_ar[m] == s1_ar[k]) l1[k] = alloc_pr[m];
        if (rn[m] && d_ar[m] == s2_ar[k]) l2[k] = alloc_pr[m];
        if (rn[m] && d_ar[m] == d_ar[k])  lo[k] = alloc_pr[m];
      end
      if (!rn[k]) lo[k] = '0;
    end
  end

  always_comb begin
    arat_next = arat_reg;
    for (int k = 0; k < 4; k++)
      if (retire_valid[k] && r_ar[k] != '0) arat_next[r_ar[k]] = r_pr[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NAR; i++) begin
        arat_reg[i] <= PR_W'(i);
        srat_reg[i] <= PR_W'(i);
      end
    end else begin
      arat_reg <= arat_next;
      if (flush_stage4) srat_reg <= arat_next;
      else if (fire) begin
        for (int k = 0; k < 4; k++)
          if (rn[k]) srat_reg[d_ar[k]] <= alloc_pr[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= '0;
      src1_PR   <= '0;
      src2_PR   <= '0;
      dst_PR    <= '0;
      old_PR    <= '0;
    end else if (flush_stage4) begin
      out_valid <= '0;
    end else if (!stage4_pause) begin
      if (rename_stall) out_valid <= '0;
      else begin
        out_valid <= in_valid;
        for (int k = 0; k < 4; k++) begin
          src1_PR[k*PR_W +: PR_W] <= l1[k];
          src2_PR[k*PR_W +: PR_W] <= l2[k];
          dst_PR[k*PR_W +: PR_W]  <= alloc_pr[k];
          old_PR[k*PR_W +: PR_W]  <= lo[k];
        end
      end
    end
  end

`ifdef RENAME_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) stall_cnt <= '0;
    else if (rename_stall && (|in_valid) && !flush_stage4) stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_rename_rat.sv
// Directed testbench for rename_rat: hand-computed rename, bypass, stall, flush, pause, reset cases.
module tb_rename_rat;
  logic        clk = 1'b0;
  logic        rst, flush_stage4, stage4_pause;
  logic [3:0]  in_valid, dst_wen, retire_valid;
  logic [19:0] src1_AR, src2_AR, dst_AR, retire_AR;
  logic [23:0] free_PR, retire_PR;
  logic [5:0]  freelist_room;
  logic [2:0]  PR_num_need;
  logic        rename_stall;
  logic [3:0]  out_valid;
  logic [23:0] src1_PR, src2_PR, dst_PR, old_PR;
`ifdef RENAME_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rename_rat dut (
    .clk(clk), .rst(rst), .flush_stage4(flush_stage4), .stage4_pause(stage4_pause),
    .in_valid(in_valid), .src1_AR(src1_AR), .src2_AR(src2_AR), .dst_AR(dst_AR),
    .dst_wen(dst_wen), .free_PR(free_PR), .freelist_room(freelist_room),
    .PR_num_need(PR_num_need), .rename_stall(rename_stall), .out_valid(out_valid),
    .src1_PR(src1_PR), .src2_PR(src2_PR), .dst_PR(dst_PR), .old_PR(old_PR),
    .retire_valid(retire_valid), .retire_AR(retire_AR), .retire_PR(retire_PR)
`ifdef RENAME_PERF_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else
      $display("ok   %s: %0d", tag, got);
  endtask

  function automatic logic [5:0] pr(input logic [23:0] v, input int k);
    return v[k*6 +: 6];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    in_valid = '0; dst_wen = '0; src1_AR = '0; src2_AR = '0; dst_AR = '0; free_PR = '0;
  endtask

  task automatic slot(input int k, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [4:0] d, input logic w);
    in_valid[k] = 1'b1;
    src1_AR[k*5 +: 5] = s1;
    src2_AR[k*5 +: 5] = s2;
    dst_AR[k*5 +: 5]  = d;
    dst_wen[k] = w;
  endtask

  task automatic set_free(input int j, input logic [5:0] p);
    free_PR[j*6 +: 6] = p;
  endtask

  initial begin
    rst = 1'b1; flush_stage4 = 1'b0; stage4_pause = 1'b0; freelist_room = 6'd10;
    retire_valid = '0; retire_AR = '0; retire_PR = '0;
    clear();
    tick(); tick();
    rst = 1'b0;
    check("reset out_valid", 32'(out_valid), 0);
    check("reset dst_PR", 32'(dst_PR), 0);
    check("reset src1_PR", 32'(src1_PR), 0);

    // basic rename r5 -> 32
    clear(); slot(0, 5'd5, 5'd0, 5'd5, 1'b1); set_free(0, 6'd32);
    #1;
    check("t1 need", 32'(PR_num_need), 1);
    check("t1 stall", 32'(rename_stall), 0);
    tick();
    check("t1 out_valid", 32'(out_valid), 1);
    check("t1 src1_PR0", 32'(pr(src1_PR, 0)), 5);
    check("t1 dst_PR0", 32'(pr(dst_PR, 0)), 32);
    check("t1 old_PR0", 32'(pr(old_PR, 0)), 5);

    // bypass slot0 r3 -> slot1 source
    clear(); slot(0, 5'd0, 5'd0, 5'd3, 1'b1); slot(1, 5'd3, 5'd5, 5'd4, 1'b1);
    set_free(0, 6'd40); set_free(1, 6'd41);
    #1;
    check("t2 need", 32'(PR_num_need), 2);
    tick();
    check("t2 src1_PR1", 32'(pr(src1_PR, 1)), 40);
    check("t2 src2_PR1", 32'(pr(src2_PR, 1)), 32);
    check("t2 dst_PR1", 32'(pr(dst_PR, 1)), 41);
    check("t2 old_PR1", 32'(pr(old_PR, 1)), 4);
    check("t2 old_PR0", 32'(pr(old_PR, 0)), 3);

    // slots 0 and 2 both write r7
    clear(); slot(0, 5'd7, 5'd0, 5'd7, 1'b1); slot(2, 5'd7, 5'd0, 5'd7, 1'b1);
    set_free(0, 6'd33); set_free(1, 6'd34);
    #1;
    check("t3 need", 32'(PR_num_need), 2);
    tick();
    check("t3 out_valid", 32'(out_valid), 5);
    check("t3 dst_PR0", 32'(pr(dst_PR, 0)), 33);
    check("t3 dst_PR2", 32'(pr(dst_PR, 2)), 34);
    check("t3 old_PR0", 32'(pr(old_PR, 0)), 7);
    check("t3 old_PR2", 32'(pr(old_PR, 2)), 33);
    check("t3 src1_PR0 own dst", 32'(pr(src1_PR, 0)), 7);
    check("t3 src1_PR2 bypass", 32'(pr(src1_PR, 2)), 33);
    clear(); slot(0, 5'd7, 5'd0, 5'd0, 1'b0); slot(3, 5'd3, 5'd0, 5'd0, 1'b0);
    #1;
    check("t3b need", 32'(PR_num_need), 0);
    tick();
    check("t3b src1_PR0 r7", 32'(pr(src1_PR, 0)), 34);
    check("t3b dst_PR0", 32'(pr(dst_PR, 0)), 0);
    check("t3b src1_PR3 r3", 32'(pr(src1_PR, 3)), 40);

    // insufficient room
    clear(); slot(0, 5'd0, 5'd0, 5'd10, 1'b1); slot(1, 5'd0, 5'd0, 5'd11, 1'b1);
    slot(2, 5'd0, 5'd0, 5'd12, 1'b1);
    set_free(0, 6'd50); set_free(1, 6'd51); set_free(2, 6'd52);
    freelist_room = 6'd2;
    #1;
    check("t4 stall", 32'(rename_stall), 1);
    check("t4 need", 32'(PR_num_need), 0);
    tick();
    check("t4 out_valid", 32'(out_valid), 0);
`ifdef RENAME_PERF_CNT_EN
    check("t4 stall_cnt", stall_cnt, 1);
`endif
    freelist_room = 6'd10;
    clear(); slot(0, 5'd10, 5'd11, 5'd0, 1'b0);
    #1;
    check("t4b stall", 32'(rename_stall), 0);
    tick();
    check("t4b src1 r10", 32'(pr(src1_PR, 0)), 10);
    check("t4b src2 r11", 32'(pr(src2_PR, 0)), 11);

    // flush with same-cycle retire
    clear(); slot(0, 5'd0, 5'd0, 5'd9, 1'b1); set_free(0, 6'd45);
    retire_valid = 4'b0001; retire_AR = 20'd9; retire_PR = 24'd41; flush_stage4 = 1'b1;
    #1;
    check("t5 need", 32'(PR_num_need), 0);
    tick();
    check("t5 out_valid", 32'(out_valid), 0);
    flush_stage4 = 1'b0; retire_valid = '0;
    clear(); slot(0, 5'd9, 5'd3, 5'd0, 1'b0);
    tick();
    check("t5 src1 r9", 32'(pr(src1_PR, 0)), 41);
    check("t5 src2 r3", 32'(pr(src2_PR, 0)), 3);
    check("t5 out_valid", 32'(out_valid), 1);

    // duplicate retire AR and retire to r0
    clear();
    retire_valid = 4'b0111;
    retire_AR = {5'd0, 5'd0, 5'd2, 5'd2};
    retire_PR = {6'd0, 6'd63, 6'd61, 6'd60};
    tick();
    retire_valid = '0; flush_stage4 = 1'b1;
    tick();
    flush_stage4 = 1'b0;
    slot(0, 5'd2, 5'd0, 5'd0, 1'b0);
    tick();
    check("t5b src1 r2", 32'(pr(src1_PR, 0)), 61);
    check("t5b src2 r0", 32'(pr(src2_PR, 0)), 0);

    // pause holds outputs and sRAT
    clear(); slot(0, 5'd0, 5'd0, 5'd13, 1'b1); set_free(0, 6'd46);
    tick();
    check("t6 dst_PR0", 32'(pr(dst_PR, 0)), 46);
    stage4_pause = 1'b1;
    clear(); slot(0, 5'd0, 5'd0, 5'd14, 1'b1); set_free(0, 6'd47);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("t6 pause need", 32'(PR_num_need), 0);
      tick();
      check("t6 pause dst_PR0", 32'(pr(dst_PR, 0)), 46);
      check("t6 pause out_valid", 32'(out_valid), 1);
    end
    stage4_pause = 1'b0;
    clear(); slot(0, 5'd14, 5'd0, 5'd0, 1'b1); set_free(0, 6'd47);
    #1;
    check("t6 r0 dst need", 32'(PR_num_need), 0);
    tick();
    check("t6 src1 r14", 32'(pr(src1_PR, 0)), 14);
    check("t6 r0 dst_PR0", 32'(pr(dst_PR, 0)), 0);
    check("t6 r0 out_valid", 32'(out_valid), 1);

    // reset mid-group
    clear(); slot(0, 5'd0, 5'd0, 5'd15, 1'b1); set_free(0, 6'd48);
    rst = 1'b1;
    tick();
    check("t7 out_valid", 32'(out_valid), 0);
    check("t7 dst_PR", 32'(dst_PR), 0);
    rst = 1'b0;
    clear(); slot(0, 5'd15, 5'd9, 5'd0, 1'b0);
    tick();
    check("t7 src1 r15", 32'(pr(src1_PR, 0)), 15);
    check("t7 src2 r9", 32'(pr(src2_PR, 0)), 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
